// File: rtl/pipelined_hierarch_adder_pkg.sv
// Shared arithmetic constants and parameter legality helpers for the chunked adder.
package pipelined_hierarch_adder_pkg;

  localparam int unsigned CHUNK_W   = 4;
  localparam int unsigned MIN_WIDTH = 8;

  // A legal operand width is a whole number of chunks and at least two chunks wide.
  function automatic bit width_legal(input int unsigned w);
    return (w >= MIN_WIDTH) && ((w % CHUNK_W) == 0);
  endfunction

endpackage

// File: rtl/lookahead_adder_4bit.sv
// Single-level 4-bit carry-lookahead adder; purely combinational.
module lookahead_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum_c,
  output logic       cout_c
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened generate/propagate carries, no ripple inside the chunk.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & cin);

  assign sum_c  = p ^ c[3:0];
  assign cout_c = c[4];

endmodule

// File: rtl/pipelined_hierarch_adder.sv
// Pipelined add/subtract: one 4-bit lookahead chunk per stage, carry passed stage to stage.
module pipelined_hierarch_adder
  import pipelined_hierarch_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK_W;

  if (!width_legal(WIDTH)) begin : g_width_check
    $fatal(1, "pipelined_hierarch_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  // Whole pipeline moves together; it only freezes when a finished result is unclaimed.
  logic advance_c;
  assign advance_c = !out_valid || out_ready;
  assign in_ready  = advance_c;

  logic             v0_q;
  logic             c0_q;
  logic [WIDTH-1:0] a0_q;
  logic [WIDTH-1:0] b0_q;

  // Operand capture with subtraction folded into inverted B and forced carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      c0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
    end else if (advance_c) begin
      v0_q <= in_valid;
      c0_q <= sub | carry_in;
      a0_q <= a;
      b0_q <= b ^ {WIDTH{sub}};
    end
  end

  for (genvar k = 0; k < int'(NCHUNK); k++) begin : g_stage
    localparam int unsigned REM_W = WIDTH - unsigned'(k) * CHUNK_W;
    localparam int unsigned LO_W  = (unsigned'(k) + 1) * CHUNK_W;

    logic [REM_W-1:0]   a_rem;
    logic [REM_W-1:0]   b_rem;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] s_chunk;
    logic               c_src;
    logic               v_src;
    logic               c_chunk;
    logic [LO_W-1:0]    s_nxt;
    logic [LO_W-1:0]    s_q;
    logic               v_q;
    logic               c_q;

    if (k == 0) begin : g_src
      assign a_rem = a0_q;
      assign b_rem = b0_q;
      assign c_src = c0_q;
      assign v_src = v0_q;
      assign s_nxt = s_chunk;
    end else begin : g_src
      assign a_rem = g_stage[k-1].g_ops.a_q;
      assign b_rem = g_stage[k-1].g_ops.b_q;
      assign c_src = g_stage[k-1].c_q;
      assign v_src = g_stage[k-1].v_q;
      assign s_nxt = {s_chunk, g_stage[k-1].s_q};
    end

    assign a_chunk = a_rem[CHUNK_W-1:0];
    assign b_chunk = b_rem[CHUNK_W-1:0];

    lookahead_adder_4bit u_cla (
      .a      (a_chunk),
      .b      (b_chunk),
      .cin    (c_src),
      .sum_c  (s_chunk),
      .cout_c (c_chunk)
    );

    // Finished low result bits, chunk carry and valid bit advance in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance_c) begin
        v_q <= v_src;
        c_q <= c_chunk;
        s_q <= s_nxt;
      end
    end

    if (k < int'(NCHUNK) - 1) begin : g_ops
      logic [REM_W-CHUNK_W-1:0] a_q;
      logic [REM_W-CHUNK_W-1:0] b_q;

      // Unconsumed upper operand chunks wait here until their carry arrives.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance_c) begin
          a_q <= a_rem[REM_W-1:CHUNK_W];
          b_q <= b_rem[REM_W-1:CHUNK_W];
        end
      end
    end else begin : g_last
      logic ov_q;

      // Carry into the MSB is recovered from the MSB operand and sum bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (advance_c) begin
          ov_q <= a_chunk[CHUNK_W-1] ^ b_chunk[CHUNK_W-1] ^ s_chunk[CHUNK_W-1] ^ c_chunk;
        end
      end
    end
  end

  assign out_valid = g_stage[NCHUNK-1].v_q;
  assign sum       = g_stage[NCHUNK-1].s_q;
  assign carry_out = g_stage[NCHUNK-1].c_q;
  assign overflow  = g_stage[NCHUNK-1].g_last.ov_q;

endmodule

// File: tb/tb_pipelined_hierarch_adder.sv
// Scoreboard bench for pipelined_hierarch_adder at WIDTH=16.
module tb_pipelined_hierarch_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LAT   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ov;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  pipelined_hierarch_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t    e;
    longint  ua, ub, r, sa, sb, ideal;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (sv) begin
      r     = ua - ub;
      ideal = sa - sb;
      e.co  = (ua >= ub);
    end else begin
      r     = ua + ub + longint'(cv);
      ideal = sa + sb + longint'(cv);
      e.co  = (r >= (64'sd1 <<< WIDTH));
    end
    e.sum = WIDTH'(r);
    e.ov  = (ideal < -(64'sd1 <<< (WIDTH - 1))) || (ideal > ((64'sd1 <<< (WIDTH - 1)) - 1));
    return e;
  endfunction

  // Monitor: compare the head of the scoreboard whenever a result is presented.
  always @(negedge clk) begin
    #2;
    if (mon_en && out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin
        mon_e = sb_q[0];
        check("sum", 64'(sum), 64'(mon_e.sum));
        check("carry_out", 64'(carry_out), 64'(mon_e.co));
        check("overflow", 64'(overflow), 64'(mon_e.ov));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  // Issue one operation starting at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                      input logic sv, input exp_t e, output int acc, output int waits);
    bit done;
    done     = 1'b0;
    acc      = 0;
    a        = av;
    b        = bv;
    carry_in = cv;
    sub      = sv;
    in_valid = 1'b1;
    for (waits = 0; waits < 200; waits++) begin
      #2;
      if (in_ready) begin
        sb_q.push_back(e);
        acc  = cyc + 1;
        done = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!done) check("send_timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic sv, input logic [WIDTH-1:0] es,
                          input logic eco, input logic eov, output int waits);
    exp_t e;
    int   acc;
    bit   seen;
    e.sum     = es;
    e.co      = eco;
    e.ov      = eov;
    out_ready = 1'b1;
    seen      = 1'b0;
    send(av, bv, cv, sv, e, acc, waits);
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #2;
      if (out_valid) begin
        seen = 1'b1;
        check({name, "_latency"}, 64'(cyc - acc), 64'(LAT));
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({name, "_no_result"}, 64'(out_valid), 64'(1));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    int               acc, waits;
    logic [WIDTH-1:0] av, bv, snap;
    logic             cv, sv;
    bit               hit, rnd_done;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_carry_out", 64'(carry_out), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed corner cases
    directed("ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, waits);
    directed("wrap", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, waits);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, waits);
    directed("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, waits);
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, waits);
    drain();

    // Back-pressure: six back-to-back operations, three-cycle hold mid-stream
    out_ready = 1'b1;
    hit       = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          av = WIDTH'($urandom);
          bv = WIDTH'($urandom);
          cv = 1'($urandom);
          sv = 1'($urandom);
          send(av, bv, cv, sv, model(av, bv, cv, sv), acc, waits);
        end
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 50 && !hit; t++) begin
          @(negedge clk);
          #2;
          hit = out_valid;
        end
        check("bp_stream_started", 64'(hit), 64'(1));
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        snap = sum;
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        repeat (2) begin
          @(negedge clk);
          #2;
          check("bp_in_ready", 64'(in_ready), 64'(0));
          check("bp_out_valid", 64'(out_valid), 64'(1));
          check("bp_sum_stable", 64'(sum), 64'(snap));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight
    out_ready = 1'b1;
    av = 16'h1234; bv = 16'h4321;
    send(av, bv, 1'b0, 1'b0, model(av, bv, 1'b0, 1'b0), acc, waits);
    av = 16'hABCD; bv = 16'h0101;
    send(av, bv, 1'b0, 1'b1, model(av, bv, 1'b0, 1'b1), acc, waits);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_sum", 64'(sum), 64'(0));
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    directed("post_rst", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, waits);
    check("post_rst_first_edge_accept", 64'(waits), 64'(0));
    drain();

    // Random streaming with random downstream stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
          av = WIDTH'($urandom);
          bv = WIDTH'($urandom);
          cv = 1'($urandom);
          sv = 1'($urandom);
          send(av, bv, cv, sv, model(av, bv, cv, sv), acc, waits);
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
